// File: rtl/pal_pad_scheduler.sv
// Schedules the NTSC->PAL line-padding window (Line24) and the per-padded-line
// VClkPulse for the VDG clock interposer, tracking VDG field and line sync.
module pal_pad_scheduler #(
    parameter int unsigned PRE_LINES = 24,
    parameter int unsigned PAD_LINES = 50,
    parameter int unsigned MAX_LINES = 320,
    parameter int unsigned LW        = 9
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          Enable,
    input  logic          nHSync,
    input  logic          nFSync,
    output logic          Line24,
    output logic          VClkPulse,
    output logic [LW-1:0] LineCount,
    output logic [1:0]    State,
    output logic          Overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_PAD  = 2'b10,
        ST_POST = 2'b11
    } state_t;

    localparam logic [LW-1:0] PRE_END = LW'(PRE_LINES);
    localparam logic [LW-1:0] PAD_END = LW'(PRE_LINES + PAD_LINES);
    localparam logic [LW-1:0] MAX_CNT = LW'(MAX_LINES);

    logic          r_hs_s1, r_hs_s2, r_hs_prev;
    logic          r_fs_s1, r_fs_s2, r_fs_prev;
    logic          w_hs_fall, w_fs_fall;

    state_t        r_state, w_state_nx;
    logic          r_line24, w_line24_nx;
    logic          r_vclk, w_vclk_nx;
    logic [LW-1:0] r_count, w_count_nx, w_count_inc;
    logic          r_overrun, w_overrun_nx;

    // Two-flop synchronisers plus previous-value flop; idle level is high.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_hs_s1   <= 1'b1;
            r_hs_s2   <= 1'b1;
            r_hs_prev <= 1'b1;
            r_fs_s1   <= 1'b1;
            r_fs_s2   <= 1'b1;
            r_fs_prev <= 1'b1;
        end else begin
            r_hs_s1   <= nHSync;
            r_hs_s2   <= r_hs_s1;
            r_hs_prev <= r_hs_s2;
            r_fs_s1   <= nFSync;
            r_fs_s2   <= r_fs_s1;
            r_fs_prev <= r_fs_s2;
        end
    end

    assign w_hs_fall   = r_hs_prev & ~r_hs_s2;
    assign w_fs_fall   = r_fs_prev & ~r_fs_s2;
    assign w_count_inc = r_count + LW'(1);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_line24  <= 1'b0;
            r_vclk    <= 1'b0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_line24  <= w_line24_nx;
            r_vclk    <= w_vclk_nx;
            r_count   <= w_count_nx;
            r_overrun <= w_overrun_nx;
        end
    end

    // Field sync takes priority over a coincident line sync; the overrun limit
    // is tested before any window transition so the counter never wraps.
    always_comb begin
        w_state_nx   = r_state;
        w_line24_nx  = r_line24;
        w_vclk_nx    = 1'b0;
        w_count_nx   = r_count;
        w_overrun_nx = r_overrun;

        if (!Enable) begin
            w_state_nx  = ST_IDLE;
            w_line24_nx = 1'b0;
        end else if (w_fs_fall) begin
            w_state_nx   = ST_PRE;
            w_line24_nx  = 1'b0;
            w_count_nx   = '0;
            w_overrun_nx = 1'b0;
        end else if (w_hs_fall && (r_state != ST_IDLE)) begin
            w_count_nx = w_count_inc;
            if (w_count_inc == MAX_CNT) begin
                w_state_nx   = ST_IDLE;
                w_line24_nx  = 1'b0;
                w_overrun_nx = 1'b1;
            end else begin
                case (r_state)
                    ST_PRE: begin
                        if (w_count_inc == PRE_END) begin
                            if (PAD_LINES == 0) begin
                                w_state_nx = ST_POST;
                            end else begin
                                w_state_nx  = ST_PAD;
                                w_line24_nx = 1'b1;
                                w_vclk_nx   = 1'b1;
                            end
                        end
                    end
                    ST_PAD: begin
                        if (w_count_inc == PAD_END) begin
                            w_state_nx  = ST_POST;
                            w_line24_nx = 1'b0;
                        end else begin
                            w_vclk_nx = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Line24    = r_line24;
    assign VClkPulse = r_vclk;
    assign LineCount = r_count;
    assign State     = r_state;
    assign Overrun   = r_overrun;

endmodule

// File: tb/tb_pal_pad_scheduler.sv
// Scoreboard bench for pal_pad_scheduler: a line-level model queues the
// expected outputs per sync event, compared once the synchroniser latency elapses.
module tb_pal_pad_scheduler;

    localparam int unsigned LW    = 9;
    localparam int unsigned PRE_L = 24;
    localparam int unsigned PAD_L = 50;
    localparam int unsigned MAX_L = 320;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PRE  = 2'b01;
    localparam logic [1:0] S_PAD  = 2'b10;
    localparam logic [1:0] S_POST = 2'b11;

    logic          clk;
    logic          nReset, Enable, nHSync, nFSync;
    logic          Line24, VClkPulse, Overrun;
    logic [LW-1:0] LineCount;
    logic [1:0]    State;
    logic          l24_0, vp_0, ov_0;
    logic [LW-1:0] cnt_0;
    logic [1:0]    st_0;

    typedef struct packed {
        logic [1:0]    st;
        logic          l24;
        logic          vp;
        logic [LW-1:0] cnt;
        logic          ov;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    bit   m_en;
    int   n_checks, n_errors;
    int   pulse_cnt, pulse0_cnt, base;
    bit   l24_seen0;
    logic vp_prev;

    pal_pad_scheduler #(.PRE_LINES(PRE_L), .PAD_LINES(PAD_L), .MAX_LINES(MAX_L), .LW(LW)) u_dut (
        .Clk(clk), .nReset(nReset), .Enable(Enable), .nHSync(nHSync), .nFSync(nFSync),
        .Line24(Line24), .VClkPulse(VClkPulse), .LineCount(LineCount), .State(State),
        .Overrun(Overrun)
    );

    pal_pad_scheduler #(.PRE_LINES(PRE_L), .PAD_LINES(0), .MAX_LINES(MAX_L), .LW(LW)) u_dut0 (
        .Clk(clk), .nReset(nReset), .Enable(Enable), .nHSync(nHSync), .nFSync(nFSync),
        .Line24(l24_0), .VClkPulse(vp_0), .LineCount(cnt_0), .State(st_0),
        .Overrun(ov_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk_eq("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            chk_eq("state",   32'(State),     32'(e.st));
            chk_eq("line24",  32'(Line24),    32'(e.l24));
            chk_eq("vclk",    32'(VClkPulse), 32'(e.vp));
            chk_eq("count",   32'(LineCount), 32'(e.cnt));
            chk_eq("overrun", 32'(Overrun),   32'(e.ov));
        end
    endtask

    // Pulse bookkeeping: width, legality against state, and running totals.
    always @(negedge clk) begin
        if (VClkPulse === 1'b1) begin
            pulse_cnt++;
            chk_eq("vclk_in_pad", 32'(State), 32'(S_PAD));
            chk_eq("vclk_wide", 32'(vp_prev), 32'(0));
        end
        vp_prev = VClkPulse;
        if (vp_0 === 1'b1) pulse0_cnt++;
        if (l24_0 === 1'b1) l24_seen0 = 1'b1;
    end

    task automatic line_event(input bit hs, input bit fs);
        exp_t prev;
        logic [LW-1:0] inc;
        prev = m;
        m.vp = 1'b0;
        if (fs && m_en) begin
            m.st = S_PRE; m.l24 = 1'b0; m.cnt = '0; m.ov = 1'b0;
        end else if (hs && m.st != S_IDLE) begin
            inc = m.cnt + LW'(1);
            m.cnt = inc;
            if (inc == LW'(MAX_L)) begin
                m.st = S_IDLE; m.l24 = 1'b0; m.ov = 1'b1;
            end else if (m.st == S_PRE && inc == LW'(PRE_L)) begin
                m.st = S_PAD; m.l24 = 1'b1; m.vp = 1'b1;
            end else if (m.st == S_PAD) begin
                if (inc == LW'(PRE_L + PAD_L)) begin
                    m.st = S_POST; m.l24 = 1'b0;
                end else begin
                    m.vp = 1'b1;
                end
            end
        end
        sb_q.push_back(m);
        @(posedge clk); #1;
        if (hs) nHSync = 1'b0;
        if (fs) nFSync = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_eq("lat_state", 32'(State),     32'(prev.st));
        chk_eq("lat_count", 32'(LineCount), 32'(prev.cnt));
        @(posedge clk); #1;
        sb_compare();
        @(posedge clk); #1;
        chk_eq("vclk_1clk", 32'(VClkPulse), 32'(0));
        nHSync = 1'b1;
        nFSync = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_en(input bit v);
        @(posedge clk); #1;
        Enable = v;
        m_en   = v;
        if (!v) begin
            m.st = S_IDLE; m.l24 = 1'b0; m.vp = 1'b0;
        end
        @(posedge clk); #1;
        chk_eq("en_state",   32'(State),     32'(m.st));
        chk_eq("en_line24",  32'(Line24),    32'(m.l24));
        chk_eq("en_count",   32'(LineCount), 32'(m.cnt));
        chk_eq("en_overrun", 32'(Overrun),   32'(m.ov));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nReset = 1'b0; Enable = 1'b1; nHSync = 1'b1; nFSync = 1'b1;
        m = '0; m_en = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk_eq("rst_state",   32'(State),     32'(S_IDLE));
        chk_eq("rst_line24",  32'(Line24),    32'(0));
        chk_eq("rst_vclk",    32'(VClkPulse), 32'(0));
        chk_eq("rst_count",   32'(LineCount), 32'(0));
        chk_eq("rst_overrun", 32'(Overrun),   32'(0));
        nReset = 1'b1;

        // Mid-field release: line syncs ignored until a field sync arrives.
        for (int i = 0; i < 3; i++) line_event(1'b1, 1'b0);

        // Nominal field of 312 lines.
        line_event(1'b0, 1'b1);
        base = pulse_cnt;
        for (int i = 1; i <= 312; i++) begin
            line_event(1'b1, 1'b0);
            if (i == 23) chk_eq("l24_before_24", 32'(Line24), 32'(0));
            if (i == 24) chk_eq("l24_rise_24",   32'(Line24), 32'(1));
            if (i == 73) chk_eq("l24_hold_73",   32'(Line24), 32'(1));
            if (i == 74) chk_eq("l24_fall_74",   32'(Line24), 32'(0));
            if (i == 100) begin
                chk_eq("pad0_state", 32'(st_0),  32'(S_POST));
                chk_eq("pad0_count", 32'(cnt_0), 32'(100));
            end
        end
        chk_eq("field_pulses", 32'(pulse_cnt - base), 32'(50));
        chk_eq("field_post",   32'(State), 32'(S_POST));

        // Missing field sync: overrun at line 320.
        line_event(1'b0, 1'b1);
        for (int i = 1; i <= 320; i++) line_event(1'b1, 1'b0);
        chk_eq("ovr_flag",   32'(Overrun),   32'(1));
        chk_eq("ovr_state",  32'(State),     32'(S_IDLE));
        chk_eq("ovr_line24", 32'(Line24),    32'(0));
        chk_eq("ovr_count",  32'(LineCount), 32'(320));
        line_event(1'b1, 1'b0);
        line_event(1'b0, 1'b1);
        chk_eq("ovr_clear", 32'(Overrun), 32'(0));

        // Coincident field and line sync: field wins, line not counted.
        line_event(1'b1, 1'b1);
        chk_eq("coinc_count", 32'(LineCount), 32'(0));
        line_event(1'b1, 1'b0);
        chk_eq("coinc_next", 32'(LineCount), 32'(1));

        // Reset in the padding window.
        for (int i = 0; i < 29; i++) line_event(1'b1, 1'b0);
        chk_eq("pre_rst_pad", 32'(State), 32'(S_PAD));
        @(posedge clk); #1;
        nReset = 1'b0;
        #1;
        chk_eq("mrst_state",   32'(State),     32'(S_IDLE));
        chk_eq("mrst_line24",  32'(Line24),    32'(0));
        chk_eq("mrst_vclk",    32'(VClkPulse), 32'(0));
        chk_eq("mrst_count",   32'(LineCount), 32'(0));
        chk_eq("mrst_overrun", 32'(Overrun),   32'(0));
        @(posedge clk); #1;
        nReset = 1'b1;
        m = '0;
        for (int i = 0; i < 3; i++) line_event(1'b1, 1'b0);

        // Enable dropped at line 40, then resumed on the next field.
        line_event(1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) line_event(1'b1, 1'b0);
        set_en(1'b0);
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) line_event(1'b1, 1'b0);
        chk_eq("en_low_pulses", 32'(pulse_cnt - base), 32'(0));
        set_en(1'b1);
        line_event(1'b1, 1'b0);
        line_event(1'b0, 1'b1);
        base = pulse_cnt;
        for (int i = 1; i <= 312; i++) line_event(1'b1, 1'b0);
        chk_eq("resume_pulses", 32'(pulse_cnt - base), 32'(50));

        chk_eq("pad0_no_l24",   32'(l24_seen0),  32'(0));
        chk_eq("pad0_no_pulse", 32'(pulse0_cnt), 32'(0));
        chk_eq("pad0_final",    32'(st_0),       32'(S_POST));
        chk_eq("sb_drained",    32'(sb_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
